bit_merger: RTL and testbench
=============================

// Module: bit_merger
// PURPOSE
//  Packet assembler: joins a data token and an address token, received on two independent
//  valid/ready channels, into one packet {data, addr}. Inverse of the packet bit-slicing
//  stage: sits at a router/PE injection port and rebuilds packets before they enter the NoC.
//  One holding slot per input channel, a registered output and full 1-packet/cycle throughput.
// PARAMETERS
//  DATA_W  7   data field width, packet bits [PKT_W-1:ADDR_W]
//  ADDR_W  4   address field width, packet bits [ADDR_W-1:0]
//  PKT_W   DATA_W+ADDR_W (11)   packet width; derived localparam, not overridable
//  CNT_W   16  width of the emitted-packet counter
// PORTS
//  clk         in   1       single clock, rising edge
//  reset       in   1       asynchronous, active-high reset
//  data_valid  in   1       data token offered
//  data_ready  out  1       data token accepted when data_valid & data_ready at an edge
//  data_in     in   DATA_W  data token
//  addr_valid  in   1       address token offered
//  addr_ready  out  1       address token accepted when addr_valid & addr_ready at an edge
//  addr_in     in   ADDR_W  address token
//  pkt_valid   out  1       assembled packet available
//  pkt_ready   in   1       downstream takes packet when pkt_valid & pkt_ready at an edge
//  pkt_out     out  PKT_W   {data, addr}
//  pkt_count   out  CNT_W   packets delivered downstream since reset; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async assert, sync release): d_full=a_full=0, pkt_valid=0, pkt_out=0, pkt_count=0.
//   Reset mid-operation discards held half-packets and any undelivered output.
//  State per slot: EMPTY/FULL flag + value register. The output register is a 1-entry stage.
//  out_free  = !pkt_valid | pkt_ready
//  merge     = d_full & a_full & out_free      (combinational)
//  data_ready = !d_full | merge;  addr_ready = !a_full | merge   (no comb path from *_valid)
//  Slot update on an edge:
//   accept & !merge  -> FULL, latch input
//   merge & accept   -> stays FULL with the new token
//   merge & !accept  -> EMPTY
//   otherwise hold.
//  Output update on an edge:
//   merge -> pkt_out <= {d_reg, a_reg}, pkt_valid <= 1
//   else if pkt_ready -> pkt_valid <= 0
//  pkt_count increments on each edge where pkt_valid & pkt_ready.
//  Latency: both tokens accepted at edge N -> pkt_valid=1 after edge N+1.
//  Tokens arriving at different edges: the packet forms at the edge after the later one.
//  Steady state: 1 packet/cycle when both inputs stream and pkt_ready=1.
//  Pairing is strictly FIFO per channel: the k-th data token pairs with the k-th address token.
//   A second data token while the address slot is empty stalls (data_ready=0); addr is symmetric.
//  Backpressure: while pkt_valid & !pkt_ready, pkt_out/pkt_valid hold stable.
//   Full slots then hold and their ready drops.
//  Upstream must hold *_valid and data stable until accepted. No combinational
//   valid->ready or in->out paths.
// TESTING
//  1 single: data 7'h55 at edge 1, addr 4'hA at edge 1
//    -> pkt_valid after edge 2, pkt_out=11'h55A; pkt_count=1 after the pkt_ready handshake.
//  2 skew: addr 4'h3 at edge 1, data 7'h7F at edge 5
//    -> addr_ready=0 over edges 2-5, pkt_out=11'h7F3 valid after edge 6.
//  3 stream: 8 pairs data=i, addr=15-i on back-to-back cycles, pkt_ready=1
//    -> 8 consecutive packets {i,15-i} with no bubbles, pkt_count=8.
//  4 backpressure: pkt_ready=0 for 5 cycles during a stream
//    -> pkt_out stable, both readys drop, no loss or reorder after release.
//  5 reset: assert reset with d_full=1 and pkt_valid=1
//    -> all outputs 0 immediately; the next pair after release forms a correct packet.
//  6 wrap: CNT_W=4, 17 packets -> pkt_count reads 1.

Source files
------------

// File: rtl/bit_merger.sv
// Packet assembler: pairs data and address tokens from two valid/ready channels
// into {data, addr} packets behind a one-entry registered output stage.
module bit_merger #(
    parameter int unsigned DATA_W = 7,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     data_valid,
    output logic                     data_ready,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     addr_valid,
    output logic                     addr_ready,
    input  logic [ADDR_W-1:0]        addr_in,
    output logic                     pkt_valid,
    input  logic                     pkt_ready,
    output logic [DATA_W+ADDR_W-1:0] pkt_out,
    output logic [CNT_W-1:0]         pkt_count
);

    localparam int unsigned PKT_W = DATA_W + ADDR_W;

    logic              d_full;
    logic              a_full;
    logic [DATA_W-1:0] d_reg;
    logic [ADDR_W-1:0] a_reg;
    logic              out_free;
    logic              merge;
    logic              d_acc;
    logic              a_acc;

    // Readys depend only on held state and pkt_ready, never on the *_valid inputs.
    always_comb begin
        out_free   = !pkt_valid || pkt_ready;
        merge      = d_full && a_full && out_free;
        data_ready = !d_full || merge;
        addr_ready = !a_full || merge;
        d_acc      = data_valid && data_ready;
        a_acc      = addr_valid && addr_ready;
    end

    // Data holding slot: a new token refills it even in the cycle it drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_full <= 1'b0;
            d_reg  <= '0;
        end else if (d_acc) begin
            d_full <= 1'b1;
            d_reg  <= data_in;
        end else if (merge) begin
            d_full <= 1'b0;
        end
    end

    // Address holding slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_full <= 1'b0;
            a_reg  <= '0;
        end else if (a_acc) begin
            a_full <= 1'b1;
            a_reg  <= addr_in;
        end else if (merge) begin
            a_full <= 1'b0;
        end
    end

    // Output stage holds its packet until downstream takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_valid <= 1'b0;
            pkt_out   <= '0;
        end else if (merge) begin
            pkt_valid <= 1'b1;
            pkt_out   <= PKT_W'({d_reg, a_reg});
        end else if (pkt_ready) begin
            pkt_valid <= 1'b0;
        end
    end

    // Delivered-packet counter, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count <= '0;
        end else if (pkt_valid && pkt_ready) begin
            pkt_count <= pkt_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_bit_merger.sv
// Directed bench for bit_merger: FIFO pairing model checked every cycle plus
// literal expectations for single, skew, stream, backpressure, reset and wrap cases.
module tb_bit_merger;

    logic        clk;
    logic        reset;
    logic        data_valid;
    logic        data_ready;
    logic [6:0]  data_in;
    logic        addr_valid;
    logic        addr_ready;
    logic [3:0]  addr_in;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [10:0] pkt_out;
    logic [15:0] pkt_count;

    logic        w_data_ready;
    logic        w_addr_ready;
    logic        w_pkt_valid;
    logic [10:0] w_pkt_out;
    logic [3:0]  w_pkt_count;

    int checks = 0;
    int errors = 0;

    bit_merger #(.DATA_W(7), .ADDR_W(4), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .addr_valid(addr_valid), .addr_ready(addr_ready), .addr_in(addr_in),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_out(pkt_out),
        .pkt_count(pkt_count)
    );

    // Same stimulus, narrow counter to observe wrap-around.
    bit_merger #(.DATA_W(7), .ADDR_W(4), .CNT_W(4)) u_wrap (
        .clk(clk), .reset(reset),
        .data_valid(data_valid), .data_ready(w_data_ready), .data_in(data_in),
        .addr_valid(addr_valid), .addr_ready(w_addr_ready), .addr_in(addr_in),
        .pkt_valid(w_pkt_valid), .pkt_ready(pkt_ready), .pkt_out(w_pkt_out),
        .pkt_count(w_pkt_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: accepted tokens queued per channel; k-th delivery must be {k-th data, k-th addr}.
    logic [6:0]  dq[$];
    logic [3:0]  aq[$];
    int unsigned model_cnt = 0;
    logic        prev_hold = 1'b0;
    logic [10:0] prev_out  = '0;

    always @(negedge clk) begin
        if (reset) begin
            dq.delete();
            aq.delete();
            model_cnt = 0;
            prev_hold = 1'b0;
        end else begin
            check("count", 32'(pkt_count), 32'(model_cnt & 32'hFFFF));
            check("wrap_count", 32'(w_pkt_count), 32'(model_cnt & 32'hF));
            check("wrap_match", 32'({w_data_ready, w_addr_ready, w_pkt_valid, w_pkt_out}),
                  32'({data_ready, addr_ready, pkt_valid, pkt_out}));
            if (prev_hold) begin
                check("hold_valid", 32'(pkt_valid), 32'(1));
                check("hold_out", 32'(pkt_out), 32'(prev_out));
            end
            if (pkt_valid && pkt_ready) begin
                if (dq.size() == 0 || aq.size() == 0) begin
                    check("pair_avail", 32'(0), 32'(1));
                end else begin
                    logic [6:0] d;
                    logic [3:0] a;
                    d = dq.pop_front();
                    a = aq.pop_front();
                    check("pkt_pair", 32'(pkt_out), 32'({d, a}));
                end
                model_cnt = model_cnt + 1;
            end
            if (data_valid && data_ready) dq.push_back(data_in);
            if (addr_valid && addr_ready) aq.push_back(addr_in);
            prev_hold = pkt_valid && !pkt_ready;
            prev_out  = pkt_out;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset      = 1'b1;
        data_valid = 1'b0;
        addr_valid = 1'b0;
        data_in    = '0;
        addr_in    = '0;
        pkt_ready  = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [10:0] held;
        int idx_d;
        int idx_a;
        logic da;
        logic aa;

        reset      = 1'b1;
        data_valid = 1'b0;
        addr_valid = 1'b0;
        data_in    = '0;
        addr_in    = '0;
        pkt_ready  = 1'b0;
        step();
        check("rst_valid", 32'(pkt_valid), 32'(0));
        check("rst_out", 32'(pkt_out), 32'(0));
        check("rst_count", 32'(pkt_count), 32'(0));
        check("rst_readys", 32'({data_ready, addr_ready}), 32'(2'b11));
        step();
        reset = 1'b0;

        // Single pair.
        data_valid = 1'b1; data_in = 7'h55;
        addr_valid = 1'b1; addr_in = 4'hA;
        step();
        data_valid = 1'b0; addr_valid = 1'b0;
        check("t1_not_yet", 32'(pkt_valid), 32'(0));
        step();
        check("t1_valid", 32'(pkt_valid), 32'(1));
        check("t1_out", 32'(pkt_out), 32'h55A);
        check("t1_cnt0", 32'(pkt_count), 32'(0));
        pkt_ready = 1'b1;
        step();
        check("t1_cnt1", 32'(pkt_count), 32'(1));
        check("t1_drained", 32'(pkt_valid), 32'(0));

        // Skewed arrival.
        reset_dut();
        addr_valid = 1'b1; addr_in = 4'h3;
        step();
        addr_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t2_addr_stall", 32'(addr_ready), 32'(0));
            if (k == 3) begin
                data_valid = 1'b1; data_in = 7'h7F;
            end
            step();
        end
        data_valid = 1'b0;
        check("t2_not_yet", 32'(pkt_valid), 32'(0));
        step();
        check("t2_valid", 32'(pkt_valid), 32'(1));
        check("t2_out", 32'(pkt_out), 32'h7F3);
        pkt_ready = 1'b1;
        step();

        // Back-to-back stream.
        reset_dut();
        pkt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_valid = 1'b1; data_in = 7'(i);
            addr_valid = 1'b1; addr_in = 4'(15 - i);
            check("t3_readys", 32'({data_ready, addr_ready}), 32'(2'b11));
            step();
            if (i >= 1) check("t3_stream", 32'({pkt_valid, pkt_out}), 32'({1'b1, 7'(i - 1), 4'(16 - i)}));
        end
        data_valid = 1'b0; addr_valid = 1'b0;
        step();
        check("t3_last", 32'({pkt_valid, pkt_out}), 32'({1'b1, 7'd7, 4'd8}));
        step();
        check("t3_count", 32'(pkt_count), 32'(8));

        // Backpressure in the middle of a stream.
        reset_dut();
        idx_d = 0;
        idx_a = 0;
        held  = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            data_valid = (idx_d < 10);
            data_in    = 7'(idx_d * 3 + 1);
            addr_valid = (idx_a < 10);
            addr_in    = 4'(idx_a);
            pkt_ready  = !(cyc >= 4 && cyc < 9);
            if (cyc == 5) held = pkt_out;
            if (cyc == 7) check("t4_readys_low", 32'({data_ready, addr_ready}), 32'(0));
            if (cyc == 8) check("t4_stable", 32'({pkt_valid, pkt_out}), 32'({1'b1, held}));
            da = data_valid && data_ready;
            aa = addr_valid && addr_ready;
            step();
            if (da) idx_d++;
            if (aa) idx_a++;
        end
        check("t4_all_sent", 32'(idx_d + idx_a), 32'(20));
        check("t4_count", 32'(pkt_count), 32'(10));
        check("t4_drained", 32'(dq.size() + aq.size()), 32'(0));

        // Reset with a held data token and an undelivered packet.
        reset_dut();
        data_valid = 1'b1; data_in = 7'h11;
        addr_valid = 1'b1; addr_in = 4'h2;
        step();
        data_in = 7'h22; addr_valid = 1'b0;
        step();
        data_valid = 1'b0;
        check("t5_pre_valid", 32'({pkt_valid, pkt_out}), 32'({1'b1, 11'h112}));
        check("t5_pre_dfull", 32'(data_ready), 32'(0));
        #1 reset = 1'b1;
        #1;
        check("t5_rst_valid", 32'(pkt_valid), 32'(0));
        check("t5_rst_out", 32'(pkt_out), 32'(0));
        check("t5_rst_count", 32'(pkt_count), 32'(0));
        step();
        step();
        reset = 1'b0;
        pkt_ready  = 1'b1;
        data_valid = 1'b1; data_in = 7'h12;
        addr_valid = 1'b1; addr_in = 4'h5;
        step();
        data_valid = 1'b0; addr_valid = 1'b0;
        step();
        check("t5_after", 32'({pkt_valid, pkt_out}), 32'({1'b1, 11'h125}));
        step();

        // Counter wrap on the 4-bit instance.
        reset_dut();
        pkt_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            data_valid = 1'b1; data_in = 7'(i + 40);
            addr_valid = 1'b1; addr_in = 4'(i);
            step();
        end
        data_valid = 1'b0; addr_valid = 1'b0;
        step();
        step();
        step();
        check("t6_wrap", 32'(w_pkt_count), 32'(1));
        check("t6_count", 32'(pkt_count), 32'(17));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
